// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
//   Shares the single write port of a 32-entry register file between two
//   writeback requesters: req0 (ALU) and req1 (load unit).
//   - Round-robin arbitration. When only one requester is valid, it wins.
//     When both are valid, req[rr_ptr] wins and rr_ptr then flips.
//   - The grant in cycle N is registered onto rf_dr/rf_data_in with rf_rw=1 in
//     cycle N+1. A grant to register 0 is accepted but never written.
//   - The rs1/rs2 read addresses pass straight through. BusA/BusB return to the
//     datapath as rd_a/rd_b.
//   - stall_cnt is a saturating count of cycles in which a valid requester
//     was not granted.
//   Optional feature: define REGFILE_BYPASS_EN to forward the write being
//   committed this cycle onto rd_a/rd_b.
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   reqN_valid/dr/data       writeback request from requester N
//   reqN_ready               grant to requester N (combinational)
//   rd_rs1/rd_rs2, rd_a/rd_b datapath read addresses and operands
//   rf_*                     register file write port and read port
//   stall_cnt                saturating stall-cycle counter
module regfile_wb_arbiter #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_dr,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_dr,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    input  logic [ADDR_W-1:0] rd_rs1,
    input  logic [ADDR_W-1:0] rd_rs2,
    output logic [DATA_W-1:0] rd_a,
    output logic [DATA_W-1:0] rd_b,
    output logic [DATA_W-1:0] rf_data_in,
    output logic [ADDR_W-1:0] rf_dr,
    output logic              rf_rw,
    output logic [ADDR_W-1:0] rf_rs1,
    output logic [ADDR_W-1:0] rf_rs2,
    input  logic [DATA_W-1:0] rf_busa,
    input  logic [DATA_W-1:0] rf_busb,
    output logic [CNT_W-1:0]  stall_cnt
);

    logic              rr_ptr_q, rr_ptr_d;
    logic              rf_rw_q, rf_rw_d;
    logic [ADDR_W-1:0] rf_dr_q, rf_dr_d;
    logic [DATA_W-1:0] rf_data_q, rf_data_d;
    logic [CNT_W-1:0]  stall_q, stall_d;

    logic              gnt0, gnt1;
    logic              stall_now;
    logic [ADDR_W-1:0] sel_dr;
    logic [DATA_W-1:0] sel_data;

    // Grants: a lone valid requester always wins; under contention rr_ptr picks.
    always_comb begin
        gnt0      = !rst && req0_valid && (!req1_valid || !rr_ptr_q);
        gnt1      = !rst && req1_valid && (!req0_valid || rr_ptr_q);
        stall_now = (req0_valid && !gnt0) || (req1_valid && !gnt1);
        sel_dr    = gnt1 ? req1_dr : req0_dr;
        sel_data  = gnt1 ? req1_data : req0_data;
    end

    always_comb begin
        rr_ptr_d  = rr_ptr_q;
        rf_rw_d   = 1'b0;
        rf_dr_d   = rf_dr_q;
        rf_data_d = rf_data_q;
        stall_d   = stall_q;

        // Register 0 is hard-wired: the grant completes but nothing is staged,
        // so rf_dr/rf_data_in keep their previous values.
        if ((gnt0 || gnt1) && (sel_dr != '0)) begin
            rf_rw_d   = 1'b1;
            rf_dr_d   = sel_dr;
            rf_data_d = sel_data;
        end

        // Pointer moves only when a contended grant was made.
        if (gnt0 && req1_valid) begin
            rr_ptr_d = 1'b1;
        end else if (gnt1 && req0_valid) begin
            rr_ptr_d = 1'b0;
        end

        if (stall_now && (stall_q != '1)) begin
            stall_d = stall_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q  <= 1'b0;
            rf_rw_q   <= 1'b0;
            rf_dr_q   <= '0;
            rf_data_q <= '0;
            stall_q   <= '0;
        end else begin
            rr_ptr_q  <= rr_ptr_d;
            rf_rw_q   <= rf_rw_d;
            rf_dr_q   <= rf_dr_d;
            rf_data_q <= rf_data_d;
            stall_q   <= stall_d;
        end
    end

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;
    assign rf_rw      = rf_rw_q;
    assign rf_dr      = rf_dr_q;
    assign rf_data_in = rf_data_q;
    assign stall_cnt  = stall_q;
    assign rf_rs1     = rd_rs1;
    assign rf_rs2     = rd_rs2;

`ifdef REGFILE_BYPASS_EN
    // Forward the write committing this cycle; the regfile still shows the old value.
    assign rd_a = (rf_rw_q && (rf_dr_q == rd_rs1) && (rd_rs1 != '0)) ? rf_data_q : rf_busa;
    assign rd_b = (rf_rw_q && (rf_dr_q == rd_rs2) && (rd_rs2 != '0)) ? rf_data_q : rf_busb;
`else
    assign rd_a = rf_busa;
    assign rd_b = rf_busb;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;

    localparam int DW = 32;
    localparam int AW = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          v0, v1;
    logic [AW-1:0] dr0, dr1, rs1, rs2;
    logic [DW-1:0] d0, d1;

    logic          rdy0, rdy1, rf_rw;
    logic [DW-1:0] rd_a, rd_b, rf_data_in, busa, busb;
    logic [AW-1:0] rf_dr, rf_rs1, rf_rs2;
    logic [15:0]   stall_cnt;

    // Second instance with a 2-bit counter to exercise saturation.
    logic          s_rdy0, s_rdy1, s_rw;
    logic [DW-1:0] s_rd_a, s_rd_b, s_data_in, s_busa, s_busb;
    logic [AW-1:0] s_dr, s_rs1, s_rs2;
    logic [1:0]    s_stall;

    // Environment register file fed by the DUT write port.
    logic [DW-1:0] rf_mem [32];
    assign busa   = rf_mem[rf_rs1];
    assign busb   = rf_mem[rf_rs2];
    assign s_busa = rf_mem[s_rs1];
    assign s_busb = rf_mem[s_rs2];
    always @(posedge clk) if (rf_rw) rf_mem[rf_dr] <= rf_data_in;

    regfile_wb_arbiter #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(v0), .req0_dr(dr0), .req0_data(d0), .req0_ready(rdy0),
        .req1_valid(v1), .req1_dr(dr1), .req1_data(d1), .req1_ready(rdy1),
        .rd_rs1(rs1), .rd_rs2(rs2), .rd_a(rd_a), .rd_b(rd_b),
        .rf_data_in(rf_data_in), .rf_dr(rf_dr), .rf_rw(rf_rw),
        .rf_rs1(rf_rs1), .rf_rs2(rf_rs2), .rf_busa(busa), .rf_busb(busb),
        .stall_cnt(stall_cnt)
    );

    regfile_wb_arbiter #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst),
        .req0_valid(v0), .req0_dr(dr0), .req0_data(d0), .req0_ready(s_rdy0),
        .req1_valid(v1), .req1_dr(dr1), .req1_data(d1), .req1_ready(s_rdy1),
        .rd_rs1(rs1), .rd_rs2(rs2), .rd_a(s_rd_a), .rd_b(s_rd_b),
        .rf_data_in(s_data_in), .rf_dr(s_dr), .rf_rw(s_rw),
        .rf_rs1(s_rs1), .rf_rs2(s_rs2), .rf_busa(s_busa), .rf_busb(s_busb),
        .stall_cnt(s_stall)
    );

    int checks = 0;
    int errors = 0;

    // Behavioural model: who is favoured, what write is committing, memory image.
    int            m_fav;
    bit            m_known;
    bit            m_rw;
    logic [AW-1:0] m_dr;
    logic [DW-1:0] m_data;
    int            m_stall, m_sstall;
    logic [DW-1:0] m_mem [32];
    bit            e0, e1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input bit r,
                        input bit a0, input logic [AW-1:0] a0dr, input logic [DW-1:0] a0d,
                        input bit a1, input logic [AW-1:0] a1dr, input logic [DW-1:0] a1d,
                        input logic [AW-1:0] s1, input logic [AW-1:0] s2);
        logic [DW-1:0] ea, eb;
        bit stalled;
        @(negedge clk);
        rst = r; v0 = a0; dr0 = a0dr; d0 = a0d; v1 = a1; dr1 = a1dr; d1 = a1d;
        rs1 = s1; rs2 = s2;
        #1;
        if (r) begin
            e0 = 1'b0; e1 = 1'b0;
        end else if (a0 && a1) begin
            e0 = (m_fav == 0); e1 = (m_fav == 1);
        end else begin
            e0 = a0; e1 = a1;
        end
        ea = m_mem[s1];
        eb = m_mem[s2];
`ifdef REGFILE_BYPASS_EN
        if (m_rw && m_dr == s1 && s1 != 0) ea = m_data;
        if (m_rw && m_dr == s2 && s2 != 0) eb = m_data;
`endif
        chk("ready0", 64'(rdy0), 64'(e0));
        chk("ready1", 64'(rdy1), 64'(e1));
        chk("rf_rs1", 64'(rf_rs1), 64'(s1));
        chk("rf_rs2", 64'(rf_rs2), 64'(s2));
        if (m_known) begin
            chk("rf_rw", 64'(rf_rw), 64'(m_rw));
            chk("rf_dr", 64'(rf_dr), 64'(m_dr));
            chk("rf_data_in", 64'(rf_data_in), 64'(m_data));
            chk("stall_cnt", 64'(stall_cnt), 64'(m_stall));
            chk("stall_cnt_sat", 64'(s_stall), 64'(m_sstall));
            chk("rd_a", 64'(rd_a), 64'(ea));
            chk("rd_b", 64'(rd_b), 64'(eb));
        end
        // Advance the model to the next cycle.
        if (m_rw) m_mem[m_dr] = m_data;
        if (r) begin
            m_known = 1; m_rw = 0; m_dr = '0; m_data = '0;
            m_stall = 0; m_sstall = 0; m_fav = 0;
        end else begin
            stalled = (a0 && !e0) || (a1 && !e1);
            if (stalled) begin
                if (m_stall < 65535) m_stall++;
                if (m_sstall < 3) m_sstall++;
            end
            if (a0 && a1) m_fav = 1 - m_fav;
            m_rw = 0;
            if (e0 && a0dr != 0) begin m_rw = 1; m_dr = a0dr; m_data = a0d; end
            if (e1 && a1dr != 0) begin m_rw = 1; m_dr = a1dr; m_data = a1d; end
        end
    endtask

    bit            pv0, pv1;
    logic [AW-1:0] pdr0, pdr1, r1, r2;
    logic [DW-1:0] pd0, pd1;

    initial begin
        for (int i = 0; i < 32; i++) begin
            rf_mem[i] = '0;
            m_mem[i]  = '0;
        end
        m_known = 0; m_rw = 0; m_dr = '0; m_data = '0; m_stall = 0; m_sstall = 0; m_fav = 0;
        rst = 1; v0 = 0; v1 = 0; dr0 = '0; dr1 = '0; d0 = '0; d1 = '0; rs1 = '0; rs2 = '0;

        // Reset with both requesters valid.
        step(1, 1, 5'd3, 32'd5, 1, 5'd4, 32'd6, 5'd0, 5'd0);
        chk("rst_ready0", 64'(rdy0), 64'd0);
        chk("rst_ready1", 64'(rdy1), 64'd0);
        step(1, 1, 5'd3, 32'd5, 1, 5'd4, 32'd6, 5'd0, 5'd0);
        chk("rst_rf_rw", 64'(rf_rw), 64'd0);
        chk("rst_stall", 64'(stall_cnt), 64'd0);

        // Single request, then read it back.
        step(0, 1, 5'd14, 32'd12, 0, 5'd0, 32'd0, 5'd0, 5'd0);
        chk("single_ready0", 64'(rdy0), 64'd1);
        step(0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 5'd14, 5'd0);
        chk("single_rw", 64'(rf_rw), 64'd1);
        chk("single_dr", 64'(rf_dr), 64'd14);
        chk("single_data", 64'(rf_data_in), 64'd12);
        step(0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 5'd14, 5'd0);
        chk("single_read", 64'(rd_a), 64'd12);

        // Contention: r0,r1,r0,r1,r0; r0's first write is read in its commit cycle.
        step(0, 1, 5'd17, 32'd42, 1, 5'd27, 32'd19, 5'd0, 5'd0);
        chk("cont1_r0", 64'({rdy0, rdy1}), 64'b10);
        step(0, 1, 5'd17, 32'd42, 1, 5'd27, 32'd19, 5'd17, 5'd0);
        chk("cont2_r1", 64'({rdy0, rdy1}), 64'b01);
`ifdef REGFILE_BYPASS_EN
        chk("bypass_rd_a", 64'(rd_a), 64'd42);
`else
        chk("bypass_rd_a", 64'(rd_a), 64'd0);
`endif
        step(0, 1, 5'd17, 32'd42, 1, 5'd27, 32'd19, 5'd0, 5'd0);
        chk("cont3_r0", 64'({rdy0, rdy1}), 64'b10);
        step(0, 1, 5'd17, 32'd42, 1, 5'd27, 32'd19, 5'd0, 5'd0);
        chk("cont4_r1", 64'({rdy0, rdy1}), 64'b01);
        step(0, 1, 5'd17, 32'd42, 1, 5'd27, 32'd19, 5'd0, 5'd0);
        chk("cont_stall4", 64'(stall_cnt), 64'd4);
        chk("cont_sat3", 64'(s_stall), 64'd3);

        // Write to register 0 is accepted but never committed.
        step(0, 0, 5'd0, 32'd0, 1, 5'd0, 32'd99, 5'd0, 5'd0);
        chk("dr0_ready1", 64'(rdy1), 64'd1);
        step(0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 5'd0, 5'd0);
        chk("dr0_rw", 64'(rf_rw), 64'd0);
        chk("dr0_read", 64'(rd_a), 64'd0);
        chk("sat_hold", 64'(s_stall), 64'd3);

        // Reset in the commit cycle, then arbitration restarts with req0 favoured.
        step(0, 1, 5'd9, 32'd77, 0, 5'd0, 32'd0, 5'd0, 5'd0);
        step(1, 1, 5'd10, 32'd5, 1, 5'd11, 32'd6, 5'd0, 5'd0);
        step(0, 1, 5'd10, 32'd5, 1, 5'd11, 32'd6, 5'd9, 5'd0);
        chk("rst_mid_rw", 64'(rf_rw), 64'd0);
        chk("rst_mid_fav", 64'({rdy0, rdy1}), 64'b10);

        // Randomized traffic with held requests and occasional withdrawal.
        pv0 = 0; pv1 = 0; pdr0 = '0; pdr1 = '0; pd0 = '0; pd1 = '0;
        for (int c = 0; c < 3000; c++) begin
            if (!pv0 && ($urandom_range(0, 1) == 1)) begin
                pv0 = 1; pdr0 = 5'($urandom_range(0, 7)); pd0 = $urandom;
            end else if (pv0 && ($urandom_range(0, 9) == 0)) begin
                pv0 = 0;
            end
            if (!pv1 && ($urandom_range(0, 1) == 1)) begin
                pv1 = 1; pdr1 = 5'($urandom_range(0, 7)); pd1 = $urandom;
            end else if (pv1 && ($urandom_range(0, 9) == 0)) begin
                pv1 = 0;
            end
            r1 = ($urandom_range(0, 1) == 1) ? m_dr : 5'($urandom_range(0, 7));
            r2 = ($urandom_range(0, 1) == 1) ? m_dr : 5'($urandom_range(0, 31));
            step(($urandom_range(0, 99) == 0), pv0, pdr0, pd0, pv1, pdr1, pd1, r1, r2);
            if (e0) pv0 = 0;
            if (e1) pv1 = 0;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
